// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: serial receive controller driving an external shift-left SIPO register.
// Ports: clk/rst_n; rx serial line (idle high); bit_tick sample strobe; sipo_data readback;
//        shift_en/bit_out to the SIPO; data_out/data_valid/data_ready word handshake;
//        frame_err/overrun single-cycle event pulses; busy whenever not idle.
module sipo_rx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             bit_tick,
  input  logic [WIDTH-1:0] sipo_data,
  output logic             shift_en,
  output logic             bit_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP, BREAK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rx_meta, rx_s;
  logic          capture;

  // rx is asynchronous; flops reset to the idle-high level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Everything advances only on bit_tick; shift_en and frame_err are combinational
  // so they last exactly the tick cycle that caused them.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    bit_out   = 1'b0;
    frame_err = 1'b0;
    capture   = 1'b0;
    if (bit_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          bit_out  = rx_s;
          cnt_nxt  = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state_nxt = STOP;
        end
        STOP: begin
          if (rx_s) begin
            capture   = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = BREAK;
          end
        end
        BREAK: begin
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A good frame is dropped only if the previous word is still held and not being taken now.
  assign overrun = capture & data_valid & ~data_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (capture) begin
      if (!data_valid || data_ready) begin
        data_out   <= sipo_data;
        data_valid <= 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

endmodule
